// File: rtl/cam_capture_scaler.sv
// Camera capture: OV7670 vsync/href/byte stream -> packed, optionally decimated pixel writes to frame-buffer port A.
// Latency: we/dout/addr are registered one pclk after the second byte of each pixel; frame_done one pclk after vsync rises.
// Backpressure: none; the frame-buffer port must accept a write on any cycle (at most one every two pclk).
module cam_capture_scaler #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int PIX_W     = 12,
  parameter int ADDR_W    = 19,
  parameter int MAX_SCALE = 2,
  parameter int CNT_W     = 8,
  parameter int SCALE_W   = (MAX_SCALE > 0) ? $clog2(MAX_SCALE + 1) : 1
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               vsync,
  input  logic               href,
  input  logic [7:0]         din,
  input  logic [1:0]         mode,
  input  logic [SCALE_W-1:0] scale,
  input  logic               pause,
  input  logic               shot,
  output logic [ADDR_W-1:0]  addr,
  output logic [PIX_W-1:0]   dout,
  output logic               we,
  output logic               frame_done,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [ADDR_W-1:0]  last_words,
  output logic               line_err
);

  // col/row saturate one past the active area so overflow stays detectable
  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int ROW_W = $clog2(HEIGHT + 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {WAIT_VS, ARMED, CAPTURE, SKIP} state_t;

  state_t             state, state_nxt;
  logic               start_cap, end_cap;
  logic               vsync_q, href_q, phase;
  logic [7:0]         b0_q;
  logic [1:0]         mode_q;
  logic [SCALE_W-1:0] scale_q, scale_eff;
  logic               shot_pending;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               vs_rise, vs_fall, href_rise, href_fall, pix_done;
  logic               in_range, dec_ok, wr_ok, drop;
  logic [11:0]        pix;
  logic [ADDR_W-1:0]  addr_inc, addr_nxt;

  assign vs_rise   = vsync & ~vsync_q;
  assign vs_fall   = ~vsync & vsync_q;
  assign href_rise = href & ~href_q;
  assign href_fall = ~href & href_q;
  assign pix_done  = href & phase;
  assign scale_eff = (scale > SCALE_W'(MAX_SCALE)) ? SCALE_W'(MAX_SCALE) : scale;
  assign addr_inc  = (addr == ADDR_MAX) ? addr : addr + 1'b1;
  assign addr_nxt  = we ? addr_inc : addr;

  // Frame state register
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= WAIT_VS;
    else     state <= state_nxt;
  end

  // Frame gating: arm on vsync, pick capture or skip at the vsync falling edge
  always_comb begin
    state_nxt = state;
    start_cap = 1'b0;
    end_cap   = 1'b0;
    case (state)
      WAIT_VS: if (vsync) state_nxt = ARMED;
      ARMED: begin
        if (vs_fall) begin
          if (!pause || shot_pending) begin
            state_nxt = CAPTURE;
            start_cap = 1'b1;
          end else begin
            state_nxt = SKIP;
          end
        end
      end
      CAPTURE: begin
        if (vs_rise) begin
          state_nxt = ARMED;
          end_cap   = 1'b1;
        end
      end
      SKIP:    if (vs_rise) state_nxt = ARMED;
      default: state_nxt = WAIT_VS;
    endcase
  end

  // Sync edge history, byte phase and first byte of the current pixel
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      phase   <= 1'b0;
      b0_q    <= 8'd0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
      phase   <= href ? ~phase : 1'b0;
      if (href && !phase) b0_q <= din;
    end
  end

  // Per-frame settings latched at capture start; shot request held until consumed there
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      mode_q       <= 2'd0;
      scale_q      <= '0;
      shot_pending <= 1'b0;
    end else begin
      if (start_cap) begin
        mode_q       <= mode;
        scale_q      <= scale_eff;
        shot_pending <= 1'b0;
      end
      if (shot) shot_pending <= 1'b1;
    end
  end

  // Pixel column within the line and row (lines with at least one pixel) within the frame
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (start_cap) begin
      col <= '0;
      row <= '0;
    end else begin
      if (href_rise) col <= '0;
      else if (pix_done && col < COL_W'(WIDTH)) col <= col + 1'b1;
      if (href_fall && col != '0 && row < ROW_W'(HEIGHT)) row <= row + 1'b1;
    end
  end

  // Pixel packing from (b0, b1) and the write/drop decision for the completing pixel
  always_comb begin
    pix = {3{b0_q[7:4]}};
    case (mode_q)
      2'd1:    pix = {b0_q[7:4], b0_q[2:0], din[7], din[4:1]};
      2'd2:    pix = {b0_q[3:0], din};
      default: pix = {3{b0_q[7:4]}};
    endcase
    in_range = (col < COL_W'(WIDTH)) && (row < ROW_W'(HEIGHT));
    dec_ok   = (((col >> scale_q) << scale_q) == col) && (((row >> scale_q) << scale_q) == row);
    wr_ok    = pix_done && (state == CAPTURE) && in_range && dec_ok;
    drop     = pix_done && (state == CAPTURE) && !in_range;
  end

  // Write port: strobe and data one cycle after byte 1, address advances after each write
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      we   <= 1'b0;
      dout <= '0;
      addr <= '0;
    end else begin
      we <= wr_ok;
      if (wr_ok) dout <= PIX_W'(pix);
      addr <= start_cap ? '0 : addr_nxt;
    end
  end

  // Frame status: end-of-frame pulse, frame count, word count and sticky overflow flag
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      last_words <= '0;
      line_err   <= 1'b0;
    end else begin
      frame_done <= end_cap;
      if (end_cap) begin
        frame_cnt  <= frame_cnt + 1'b1;
        last_words <= addr_nxt;
      end
      if (start_cap) line_err <= 1'b0;
      else if (drop) line_err <= 1'b1;
    end
  end

endmodule

// File: doc/cam_capture_scaler.md
Name: cam_capture_scaler

Overview:
Parametrised successor to the camera capture stage. Converts the OV7670 byte stream (vsync/href/data on pclk) into packed pixel words and writes them to a frame buffer write port. Adds selectable pixel format, power-of-two decimation, pause/single-shot frame gating, and frame status. Sits between the camera pins and the frame-buffer port A, in the pclk domain.

Parameters:
WIDTH, 640, active pixels per line accepted; later pixels are dropped
HEIGHT, 480, active lines per frame accepted; later lines are dropped
PIX_W, 12, output pixel word width; fixed packing is defined for 12
ADDR_W, 19, frame-buffer address width
MAX_SCALE, 2, largest decimation exponent supported by scale (1:2^MAX_SCALE)
CNT_W, 8, frame counter width

Ports:
pclk  in  1  camera pixel clock; the only clock
rst  in  1  asynchronous, active-high reset
vsync  in  1  camera vertical sync; high = vertical blank
href  in  1  camera line valid; high = data bytes valid
din  in  8  camera data byte
mode  in  2  0 = Y from YUYV, 1 = RGB565, 2 = RGB444 (xRGB); 3 is reserved and behaves as 0
scale  in  $clog2(MAX_SCALE+1)  decimation exponent s; values above MAX_SCALE are clamped to MAX_SCALE
pause  in  1  1 = skip frames
shot  in  1  single-cycle request to capture one frame while paused
addr  out  ADDR_W  write address
dout  out  PIX_W  write data
we  out  1  write enable
frame_done  out  1  one-cycle pulse when a captured frame ends
frame_cnt  out  CNT_W  number of captured frames, wraps
last_words  out  ADDR_W  number of words written in the last captured frame
line_err  out  1  sticky: a line or frame exceeded WIDTH/HEIGHT in the current or last captured frame

Behaviour:
- Reset: all outputs 0; FSM enters WAIT_VS; byte phase, counters and shot_pending are cleared.
- Clock and reset: one clock (pclk); reset is asynchronous and active-high (rst).
- FSM states:
  - WAIT_VS: waits for vsync=1, then goes to ARMED.
  - ARMED: on vsync falling edge (registered vsync 1->0), goes to CAPTURE if pause=0 or shot_pending=1, otherwise to SKIP.
    - On entering CAPTURE: latch mode/scale into mode_q/scale_q; clear addr, row, col and line_err; clear shot_pending.
  - CAPTURE: on vsync rising edge, pulse frame_done for 1 cycle, increment frame_cnt (wraps at 2^CNT_W), set last_words = addr, then go to ARMED.
  - SKIP: no writes; on vsync rising edge, go to ARMED.
- A reset mid-frame returns the FSM to WAIT_VS. The partial frame is never resumed; the next capture requires a full vsync high pulse followed by its falling edge.
- shot_pending is set by shot=1 in any state. It is consumed only at a CAPTURE entry. It is ignored (left set) while pause=0, and is consumed by the next frame.
- Byte phase: reset to 0 on every cycle with href=0; toggles on each href=1 cycle. Byte 0 is registered; the pixel completes on byte 1.
- Pixel packing, for pixel (b0, b1):
  - mode 0: {b0[7:4], b0[7:4], b0[7:4]}
  - mode 1: R = b0[7:3], G = {b0[2:0], b1[7:5]}, B = b1[4:0]; output {R[4:1], G[5:2], B[4:1]}
  - mode 2: {b0[3:0], b1[7:0]}
- col counts completed pixels in the line. It is reset at href rising.
- row increments at href falling only if col > 0 for that line.
- A pixel is written iff all of the following hold:
  - state = CAPTURE
  - col < WIDTH and row < HEIGHT
  - col[s-1:0] == 0 and row[s-1:0] == 0 (always true for s = 0)
- Pixels with col >= WIDTH or row >= HEIGHT are dropped and set line_err.
- Write timing: we=1 exactly one cycle after the byte-1 cycle, with dout = packed pixel and addr = current running address. addr increments by 1 after each write. Words per frame = (WIDTH>>s)*(HEIGHT>>s).
- addr holds its value between writes and saturates at 2^ADDR_W-1 (no wrap).
- An href drop on byte phase 1 (odd byte count) discards the orphan byte; no write occurs.
- Changes to mode/scale/pause mid-frame take effect only at the next frame start.

Test Plan:
- Reset held with vsync/href toggling -> we, frame_done, frame_cnt, addr all 0. After release, the first partial frame is not captured (WAIT_VS).
- mode=2, scale=0, 4x2 frame (WIDTH=4, HEIGHT=2), bytes b0=0x0A, b1=0xBC per pixel -> 8 writes, addr 0..7, dout=0xABC. frame_done one cycle after vsync rises; last_words=8; frame_cnt=1.
- mode=1, pixel b0=0xF8, b1=0x1F -> dout=0xF0F. mode=0, b0=0x9C -> dout=0x999.
- scale=1, WIDTH=8, HEIGHT=4, full frame -> 8 writes at cols 0,2,4,6 of rows 0,2. Sending 10 pixels on one line -> line_err=1, still 8 writes.
- pause=1 for 2 frames -> no writes, frame_cnt unchanged. shot pulse mid-frame -> exactly the next frame is captured, then skipping resumes.
- Odd byte count on a line (href drops after 3 bytes) -> 1 write only. rst asserted mid-line -> outputs 0 immediately; capture restarts only after the next full vsync pulse.
